crkt_sweep_ctrl: RTL

// Sequencer that exercises a 3-input/1-output combinational circuit under test (CUT).
// - Drives the CUT inputs a,b,c through all 8 vectors in order 000..111 (a = MSB).
// - Holds each vector for a programmable settle time, then samples y into a truth table.
// - Compares the finished table against an expected table and reports pass/fail.
// - Sits between a start source (button or bench) and the CUT; replaces hand-written stimulus sequences.
//

---
 rtl/crkt_sweep_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/crkt_sweep_ctrl.sv
// crkt_sweep_ctrl: steps a 3-input combinational CUT through all 8 input
// vectors, samples its output into a truth table after a programmable settle
// time, and compares the finished table against a golden table.
module crkt_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'b1011_0010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [7:0] mismatch_mask
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned TT_W  = 8;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(TT_W - 1);
  // Last settle count before moving to SAMPLE; only meaningful when SETTLE_CYCLES > 0
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam bit               SKIP_SETTLE = (SETTLE_CYCLES == 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]  vec_q,   vec_d;
  logic [TT_W-1:0]   tt_q,    tt_d;
  logic [TT_W-1:0]   mask_q,  mask_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              pass_q,  pass_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      tt_q    <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      tt_q    <= tt_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and next-output logic for the sweep sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    tt_d    = tt_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      // IDLE and DONE accept a start identically; DONE results clear here
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_APPLY;
          idx_d   = '0;
          tt_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          mask_d  = '0;
        end
      end

      S_APPLY: begin
        vec_d   = idx_q;
        cnt_d   = '0;
        state_d = SKIP_SETTLE ? S_SAMPLE : S_SETTLE;
      end

      // Hold the vector for exactly SETTLE_CYCLES cycles
      S_SETTLE: begin
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end
      end

      // Capture y for the current vector; the last one finishes the sweep
      S_SAMPLE: begin
        tt_d[idx_q] = y_in;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (tt_d == EXPECTED);
          mask_d  = tt_d ^ EXPECTED;
        end else begin
          idx_d   = IDX_W'(idx_q + IDX_W'(1));
          state_d = S_APPLY;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign a             = vec_q[2];
  assign b             = vec_q[1];
  assign c             = vec_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign truth_table   = tt_q;
  assign mismatch_mask = mask_q;

endmodule
